intersection_scheduler: RTL
===========================

# intersection_scheduler

Two-approach intersection scheduler that sequences the north-south (main) and east-west (side) signal heads plus a pedestrian walk phase. It arbitrates latched side-road and pedestrian requests against a main-road-priority default, enforcing minimum green, yellow and all-red clearance dwell times. It sits above the per-head light drivers and owns all phase timing; the existing 3-bit light encoding is reused per head.

## Interface

- GREEN_TICKS, 8: main-road minimum green and fixed side-road green, in ticks (>=1)
- YELLOW_TICKS, 3: yellow dwell, in ticks (>=1)
- ALLRED_TICKS, 2: all-red clearance dwell, in ticks (>=1)
- WALK_TICKS, 5: pedestrian walk dwell, in ticks (>=1)
- CNT_W, 8: dwell counter width; every *_TICKS value must be <= 2^CNT_W

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  timebase enable; dwell counter advances only when tick=1
- ew_req  in  1  side-road vehicle request (level or pulse)
- ped_req  in  1  pedestrian button (level or pulse)
- ns_light  out  3  main head {red,yellow,green}, one-hot
- ew_light  out  3  side head {red,yellow,green}, one-hot
- walk  out  1  pedestrian walk indication
- ew_pend  out  1  latched side-road request
- ped_pend  out  1  latched pedestrian request

## Operation

- States: INIT, NS_GRN, NS_YEL, AR1, WALK, AR2, EW_GRN, EW_YEL, AR3.
- Outputs by state:
  - NS_GRN: ns=001, ew=100.
  - NS_YEL: ns=010, ew=100.
  - EW_GRN: ns=100, ew=001.
  - EW_YEL: ns=100, ew=010.
  - All other states: ns=100, ew=100.
  - walk=1 only in WALK.
- Never: both heads non-red; walk=1 with either head non-red.
- Dwell counter cleared on every state entry; increments on tick.
- Timed exit: state left on the tick where count == N-1. N = ALLRED_TICKS for INIT/AR*, YELLOW_TICKS for *_YEL, WALK_TICKS for WALK, GREEN_TICKS for EW_GRN.
- Transitions:
  - INIT -> NS_GRN.
  - NS_GRN: count saturates at GREEN_TICKS-1. Exit to NS_YEL on the first tick with count == GREEN_TICKS-1 and (ew_pend or ped_pend). With no requests, stays in NS_GRN indefinitely.
  - NS_YEL -> AR1.
  - AR1 -> WALK if ped_pend; else EW_GRN if ew_pend; else NS_GRN.
  - WALK -> AR2.
  - AR2 -> EW_GRN if ew_pend; else NS_GRN.
  - EW_GRN -> EW_YEL -> AR3 -> NS_GRN.
- Request latches:
  - ew_pend set on any cycle with ew_req=1, except while in EW_GRN.
  - ped_pend set on any cycle with ped_req=1, except while in WALK.
  - ew_pend clears on the edge entering EW_GRN; ped_pend clears on the edge entering WALK. Clear beats a coincident set.
  - Requests arriving in any other state, including yellow/all-red of the same cycle, are held and served next round.

## Timing

- Asynchronous reset values: state=INIT, count=0, ns_light=100, ew_light=100, walk=0, ew_pend=0, ped_pend=0.
- All outputs are registered and change on the same clk edge as the state change. No combinational path from inputs to outputs.
- With tick=1 every cycle, each timed state lasts exactly N clk cycles.
- ew_req/ped_req are sampled each clk regardless of tick. A 1-cycle pulse is sufficient.
- Request latency: a request latched in NS_GRN after minimum green is acted on at the next tick (NS_YEL begins on that edge).
- Reset asserted mid-phase forces all-red immediately, without waiting for clk. After release, INIT runs a full ALLRED_TICKS before NS_GRN.
- No wrap-around: the counter never exceeds N-1.

## Test plan

- Reset: rst=1 for 5 cycles, then release with tick=1 -> ns=ew=100 and walk=0 during reset; 2 cycles all red; then ns=001, ew=100.
- Idle: no requests for 200 cycles -> ns=001 throughout, no yellow.
- Side request: 1-cycle ew_req at NS_GRN cycle 3 -> ns=001 for 8 cycles total, ns=010 ×3, all red ×2, ew=001 ×8, ew=010 ×3, all red ×2, ns=001. ew_pend clears at EW_GRN entry.
- Pedestrian only: ped_req pulse during NS_GRN -> NS_YEL ×3, AR ×2, walk=1 with both red ×5, AR ×2, back to NS_GRN with no EW phase.
- Both requests plus repeats: ew_req and ped_req together, ew_req re-pulsed during EW_GRN -> WALK then EW_GRN. The repeat is ignored and ew_pend=0 on return to NS_GRN. An ew_req during WALK is served in the same round.
- Tick gating and async reset: tick high every 4th cycle -> all dwell durations ×4. Assert rst mid EW_GRN between clk edges -> ew_light=100 immediately and both pend flags=0.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Two-approach intersection scheduler with pedestrian walk phase.
// Main road rests green; side/ped requests are latched and served in rounds.
module intersection_scheduler #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 5,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ew_pend,
  output logic       ped_pend
);

  localparam logic [3:0] INIT   = 4'd0;
  localparam logic [3:0] NS_GRN = 4'd1;
  localparam logic [3:0] NS_YEL = 4'd2;
  localparam logic [3:0] AR1    = 4'd3;
  localparam logic [3:0] WALK   = 4'd4;
  localparam logic [3:0] AR2    = 4'd5;
  localparam logic [3:0] EW_GRN = 4'd6;
  localparam logic [3:0] EW_YEL = 4'd7;
  localparam logic [3:0] AR3    = 4'd8;

  localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WLK_LAST = CNT_W'(WALK_TICKS - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic [3:0]       state;
  logic [3:0]       state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             last;
  logic [2:0]       ns_n;
  logic [2:0]       ew_n;
  logic             walk_n;
  logic             ew_clr;
  logic             ped_clr;

  always_comb begin
    last = 1'b0;
    unique case (state)
      INIT, AR1, AR2, AR3: last = (count == AR_LAST);
      NS_YEL, EW_YEL:      last = (count == YEL_LAST);
      WALK:                last = (count == WLK_LAST);
      NS_GRN, EW_GRN:      last = (count == GRN_LAST);
      default:             last = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    if (tick && last) begin
      unique case (state)
        INIT:   state_n = NS_GRN;
        NS_GRN: if (ew_pend || ped_pend) state_n = NS_YEL;
        NS_YEL: state_n = AR1;
        AR1:    state_n = ped_pend ? WALK :
                          ew_pend  ? EW_GRN : NS_GRN;
        WALK:   state_n = AR2;
        AR2:    state_n = ew_pend ? EW_GRN : NS_GRN;
        EW_GRN: state_n = EW_YEL;
        EW_YEL: state_n = AR3;
        AR3:    state_n = NS_GRN;
        default: state_n = INIT;
      endcase
    end
  end

  // Holding at last in NS_GRN gives the main-green saturation.
  always_comb begin
    count_n = count;
    if (state_n != state)
      count_n = '0;
    else if (tick && !last)
      count_n = count + 1'b1;
  end

  always_comb begin
    ns_n   = RED;
    ew_n   = RED;
    walk_n = 1'b0;
    unique case (state_n)
      NS_GRN:  ns_n = GRN;
      NS_YEL:  ns_n = YEL;
      EW_GRN:  ew_n = GRN;
      EW_YEL:  ew_n = YEL;
      WALK:    walk_n = 1'b1;
      default: ;
    endcase
  end

  assign ew_clr  = (state_n == EW_GRN) && (state != EW_GRN);
  assign ped_clr = (state_n == WALK) && (state != WALK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      count    <= '0;
      ns_light <= RED;
      ew_light <= RED;
      walk     <= 1'b0;
      ew_pend  <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      ns_light <= ns_n;
      ew_light <= ew_n;
      walk     <= walk_n;
      ew_pend  <= ew_clr ? 1'b0 :
                  (ew_pend | (ew_req && state != EW_GRN));
      ped_pend <= ped_clr ? 1'b0 :
                  (ped_pend | (ped_req && state != WALK));
    end
  end

endmodule
